// File: rtl/lsu_align.sv
// lsu_align: passes aligned loads/stores straight to data memory, splits misaligned ones into byte accesses.
// Optional MISALIGN_TRAP_EN: misaligned requests raise misalign_exc instead of being split.
module lsu_align #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_wd,
    output logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_rd,
    output logic              misalign_exc
);
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef enum logic {IDLE, SPLIT} state_e;
    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d, nlast_q, nlast_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic [23:0]       acc_q, acc_d;
    logic              mis, last;
    logic [15:0]       half;
    // funct3[1:0]: 00 byte (never misaligned), 01 halfword, others treated as word
    assign mis  = req_valid & (req_funct3[1:0] == 2'b00 ? 1'b0 :
                               req_funct3[1:0] == 2'b01 ? req_addr[0] : |req_addr[1:0]);
    assign last = idx_q == nlast_q;
    assign half = {mem_rd[7:0], acc_q[7:0]};
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nlast_d      = nlast_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        f3_d         = f3_q;
        we_d         = we_q;
        acc_d        = acc_q;
        stall        = 1'b0;
        ld_data      = 32'b0;
        misalign_exc = 1'b0;
        mem_we       = req_valid & req_we;
        mem_a        = req_addr;
        mem_wd       = req_wdata;
        mem_funct3   = req_funct3;
        if (state_q == IDLE) begin
            if (mis && TRAP) begin
                mem_we       = 1'b0;
                misalign_exc = 1'b1;
            end else if (mis) begin
                mem_funct3   = req_we ? 3'b000 : 3'b100;
                mem_wd       = {24'b0, req_wdata[7:0]};
                stall        = 1'b1;
                state_d      = SPLIT;
                idx_d        = 2'd1;
                nlast_d      = req_funct3[1:0] == 2'b01 ? 2'd1 : 2'd3;
                base_d       = req_addr;
                wdata_d      = req_wdata;
                f3_d         = req_funct3;
                we_d         = req_we;
                acc_d[7:0]   = mem_rd[7:0];
            end else if (req_valid && !req_we) begin
                ld_data = mem_rd;
            end
        end else begin
            mem_we     = we_q;
            mem_a      = base_q + ADDR_W'(idx_q);
            mem_funct3 = we_q ? 3'b000 : 3'b100;
            mem_wd     = {24'b0, wdata_q[{idx_q, 3'b000} +: 8]};
            if (last) begin
                state_d = IDLE;
                idx_d   = 2'd0;
                ld_data = we_q ? 32'b0 :
                          f3_q == 3'b001 ? {{16{half[15]}}, half} :
                          f3_q == 3'b101 ? {16'b0, half} : {mem_rd[7:0], acc_q};
            end else begin
                stall = 1'b1;
                idx_d = idx_q + 2'd1;
                if (!we_q)
                    acc_d = idx_q == 2'd1 ? {acc_q[23:16], mem_rd[7:0], acc_q[7:0]}
                                          : {mem_rd[7:0], acc_q[15:0]};
            end
        end
        // Reset overrides everything so a half-finished store stops writing at once
        if (reset) begin
            stall        = 1'b0;
            mem_we       = 1'b0;
            misalign_exc = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            nlast_q <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'b0;
            f3_q    <= 3'b0;
            we_q    <= 1'b0;
            acc_q   <= 24'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nlast_q <= nlast_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            acc_q   <= acc_d;
        end
    end
endmodule
